// File: rtl/sumador_pkg.sv
// ============================================================================
// Module      : sumador_pkg
// Description : Shared types and constants for the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Subtraction is A + ~B + 1, so the carry flop starts at one.
   localparam logic c_SUB_CIN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sumador_completo_1bit.sv
// ============================================================================
// Module      : sumador_completo_1bit
// Description : Combinational one-bit full-adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_completo_1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/sumador_serie_n.sv
// ============================================================================
// Module      : sumador_serie_n
// Description : WIDTH-bit LSB-first serial adder/subtractor, one slice per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_serie_n
   import sumador_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int c_CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-2:0]   acc_q, acc_d;
   logic               carry_q, carry_d;
   logic               msb_cin_q, msb_cin_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               w_s, w_c;

   sumador_completo_1bit u_slice (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (w_s),
      .co (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         msb_cin_q <= 1'b0;
         cnt_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         msb_cin_q <= msb_cin_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      msb_cin_d = msb_cin_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               a_sh_d  = op_a;
               b_sh_d  = sub ? ~op_b : op_b;
               carry_d = sub ? c_SUB_CIN : cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            // Accumulator keeps the low WIDTH-1 sum bits; the MSB comes straight from the slice.
            acc_d   = (WIDTH-1)'({w_s, acc_q} >> 1);
            carry_d = w_c;
            cnt_d   = cnt_q + c_CNT_W'(1);
            if (cnt_q == c_CNT_W'(WIDTH-2)) begin
               msb_cin_d = w_c;
            end
            if (cnt_q == c_CNT_W'(WIDTH-1)) begin
               sum_d   = {w_s, acc_q};
               cout_d  = w_c;
               ovf_d   = msb_cin_q ^ w_c;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign start_ready = (state_q == ST_IDLE);
   assign res_valid   = (state_q == ST_DONE);
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign ovf         = ovf_q;

endmodule

`default_nettype wire
